// File: rtl/mag_estimator_if.sv
// Sample/result bundle for the magnitude estimator.
// Handshake: in_valid qualifies in_i/in_q on every rising edge with no ready; next strobes one cycle per new amplitude.
interface mag_estimator_if;
    logic signed [15:0] in_i;
    logic signed [15:0] in_q;
    logic               in_valid;
    logic               clear_clip;
    logic        [15:0] amplitude;
    logic               next;
    logic               clip;

    modport master (
        output in_i, in_q, in_valid, clear_clip,
        input  amplitude, next, clip
    );

    modport slave (
        input  in_i, in_q, in_valid, clear_clip,
        output amplitude, next, clip
    );
endinterface

// File: rtl/mag_estimator.sv
// Alpha-max/beta-min magnitude estimate of I/Q samples, reporting the peak of every DECIM-sample window.
// Four pipeline stages: abs, sort, magnitude, window peak.
module mag_estimator #(
    parameter int DECIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    mag_estimator_if.slave  bus
);
    localparam logic [7:0] LAST = 8'(DECIM - 1);

    logic [1:0]  rst_sync;
    logic        rst_s;

    logic [14:0] abs_i, abs_q;
    logic        v1;
    logic [14:0] mx, mn;
    logic        v2;
    logic [16:0] mag_full;
    logic [15:0] mag;
    logic        v3;
    logic [15:0] peak;
    logic [15:0] peak_next;
    logic [7:0]  cnt;
    logic        clip_set;

    function automatic logic [14:0] abs15(input logic signed [15:0] x);
        if (x == 16'sh8000)
            return 15'h7fff;
        else if (x[15])
            return 15'(-x);
        else
            return x[14:0];
    endfunction

    // Reset asserts asynchronously but releases two edges later, cleanly aligned to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_s = rst_sync[1];

    assign clip_set  = bus.in_valid && (bus.in_i == 16'sh8000 || bus.in_q == 16'sh8000);
    // Both alpha and beta terms stay non-negative, so the sum never wraps in 17 bits.
    assign mag_full  = {2'b00, mx} - 17'(mx >> 4) + 17'(mn >> 1) - 17'(mn >> 5);
    assign peak_next = (mag > peak) ? mag : peak;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            abs_i         <= '0;
            abs_q         <= '0;
            v1            <= 1'b0;
            mx            <= '0;
            mn            <= '0;
            v2            <= 1'b0;
            mag           <= '0;
            v3            <= 1'b0;
            peak          <= '0;
            cnt           <= '0;
            bus.amplitude <= '0;
            bus.next      <= 1'b0;
            bus.clip      <= 1'b0;
        end else begin
            abs_i <= abs15(bus.in_i);
            abs_q <= abs15(bus.in_q);
            v1    <= bus.in_valid;

            mx <= (abs_i > abs_q) ? abs_i : abs_q;
            mn <= (abs_i > abs_q) ? abs_q : abs_i;
            v2 <= v1;

            mag <= 16'(mag_full);
            v3  <= v2;

            bus.next <= 1'b0;
            if (v3) begin
                if (cnt == LAST) begin
                    bus.amplitude <= peak_next;
                    bus.next      <= 1'b1;
                    peak          <= '0;
                    cnt           <= '0;
                end else begin
                    peak <= peak_next;
                    cnt  <= cnt + 8'd1;
                end
            end

            // A new clip event outranks a simultaneous clear.
            if (clip_set)
                bus.clip <= 1'b1;
            else if (bus.clear_clip)
                bus.clip <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mag_estimator.sv
// Directed bench for mag_estimator: one DECIM=1 and one DECIM=4 instance on a shared clock and reset.
module tb_mag_estimator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mag_estimator_if b1 ();
    mag_estimator_if b4 ();

    mag_estimator #(.DECIM(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    mag_estimator #(.DECIM(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    function automatic int ref_mag(input logic signed [15:0] i, input logic signed [15:0] q);
        int ai, aq, mxv, mnv;
        ai = (int'(i) < 0) ? -int'(i) : int'(i);
        aq = (int'(q) < 0) ? -int'(q) : int'(q);
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        mxv = (ai > aq) ? ai : aq;
        mnv = (ai > aq) ? aq : ai;
        return mxv - (mxv >> 4) + (mnv >> 1) - (mnv >> 5);
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (b1.amplitude !== 16'd0) begin errors++; $display("FAIL rst_amp1 got %0d expected 0", b1.amplitude); end
        checks++; if (b1.next !== 1'b0) begin errors++; $display("FAIL rst_next1 got %b expected 0", b1.next); end
        checks++; if (b1.clip !== 1'b0) begin errors++; $display("FAIL rst_clip1 got %b expected 0", b1.clip); end
        checks++; if (b4.amplitude !== 16'd0) begin errors++; $display("FAIL rst_amp4 got %0d expected 0", b4.amplitude); end
        checks++; if (b4.next !== 1'b0) begin errors++; $display("FAIL rst_next4 got %b expected 0", b4.next); end
        checks++; if (b4.clip !== 1'b0) begin errors++; $display("FAIL rst_clip4 got %b expected 0", b4.clip); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency();
        logic e;
        b1.in_i = 16'sd1080; b1.in_q = 16'sd0; b1.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) b1.in_valid = 1'b0;
            e = (k == 3);
            checks++; if (b1.next !== e) begin errors++; $display("FAIL lat_next k=%0d got %b expected %b", k, b1.next, e); end
            if (k == 3) begin
                checks++; if (b1.amplitude !== 16'd1013) begin errors++; $display("FAIL lat_amp got %0d expected 1013", b1.amplitude); end
                checks++; if (b1.clip !== 1'b0) begin errors++; $display("FAIL lat_clip got %b expected 0", b1.clip); end
            end
        end
    endtask

    task automatic test_swap();
        logic signed [15:0] vi [2];
        logic signed [15:0] vq [2];
        logic e;
        vi[0] = 16'sd3000; vq[0] = -16'sd4000;
        vi[1] = 16'sd4000; vq[1] = 16'sd3000;
        for (int n = 0; n < 2; n++) begin
            b1.in_i = vi[n]; b1.in_q = vq[n]; b1.in_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (k == 0) b1.in_valid = 1'b0;
                e = (k == 3);
                checks++; if (b1.next !== e) begin errors++; $display("FAIL swap_next n=%0d k=%0d got %b expected %b", n, k, b1.next, e); end
                if (k == 3) begin
                    checks++; if (b1.amplitude !== 16'd5157) begin errors++; $display("FAIL swap_amp n=%0d got %0d expected 5157", n, b1.amplitude); end
                end
            end
        end
    endtask

    task automatic test_clip();
        b1.in_i = 16'sh8000; b1.in_q = 16'sh8000; b1.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b1.in_valid = 1'b0;
                checks++; if (b1.clip !== 1'b1) begin errors++; $display("FAIL clip_set got %b expected 1", b1.clip); end
            end
            if (k == 3) begin
                checks++; if (b1.amplitude !== 16'd46080) begin errors++; $display("FAIL clip_amp got %0d expected 46080", b1.amplitude); end
                checks++; if (b1.next !== 1'b1) begin errors++; $display("FAIL clip_next got %b expected 1", b1.next); end
            end
        end
        b1.clear_clip = 1'b1;
        @(negedge clk);
        b1.clear_clip = 1'b0;
        checks++; if (b1.clip !== 1'b0) begin errors++; $display("FAIL clip_clear got %b expected 0", b1.clip); end
        @(negedge clk);
        checks++; if (b1.clip !== 1'b0) begin errors++; $display("FAIL clip_stay_clear got %b expected 0", b1.clip); end
        b1.clear_clip = 1'b1; b1.in_i = 16'sh8000; b1.in_q = 16'sd0; b1.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b1.in_valid = 1'b0;
                checks++; if (b1.clip !== 1'b1) begin errors++; $display("FAIL clip_set_wins got %b expected 1", b1.clip); end
            end
            if (k == 1) b1.clear_clip = 1'b0;
            if (k == 3) begin
                checks++; if (b1.amplitude !== 16'd30720) begin errors++; $display("FAIL clip_amp2 got %0d expected 30720", b1.amplitude); end
            end
        end
    endtask

    task automatic test_window();
        int sc [8];
        int sv [8];
        int pulses;
        logic e;
        logic [15:0] ea;
        sc = '{0, 1, 2, 3, 4, 10, 16, 22};
        sv = '{160, 800, 320, 480, 16, 16, 16, 16};
        pulses = 0;
        b4.in_q = 16'sd0;
        for (int c = 0; c < 31; c++) begin
            b4.in_valid = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if (sc[j] == c) begin
                    b4.in_valid = 1'b1;
                    b4.in_i = 16'(sv[j]);
                end
            end
            @(negedge clk);
            if (b4.next === 1'b1) pulses++;
            e  = (c == 6) || (c == 25);
            ea = (c < 6) ? 16'd0 : (c < 25) ? 16'd750 : 16'd15;
            checks++; if (b4.next !== e) begin errors++; $display("FAIL win_next c=%0d got %b expected %b", c, b4.next, e); end
            checks++; if (b4.amplitude !== ea) begin errors++; $display("FAIL win_amp c=%0d got %0d expected %0d", c, b4.amplitude, ea); end
        end
        b4.in_valid = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("FAIL win_pulses got %0d expected 2", pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic e;
        logic [15:0] ea;
        b4.in_i = 16'sd800; b4.in_q = 16'sd0; b4.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        b4.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (b4.amplitude !== 16'd0) begin errors++; $display("FAIL rmid_amp4 got %0d expected 0", b4.amplitude); end
        checks++; if (b1.clip !== 1'b0) begin errors++; $display("FAIL rmid_clip1 got %b expected 0", b1.clip); end
        checks++; if (b1.amplitude !== 16'd0) begin errors++; $display("FAIL rmid_amp1 got %0d expected 0", b1.amplitude); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (b4.next !== 1'b0) begin errors++; $display("FAIL rmid_next k=%0d got %b expected 0", k, b4.next); end
            checks++; if (b4.amplitude !== 16'd0) begin errors++; $display("FAIL rmid_hold k=%0d got %0d expected 0", k, b4.amplitude); end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        pulses = 0;
        b4.in_i = 16'sd160;
        for (int c = 0; c < 12; c++) begin
            b4.in_valid = (c < 4);
            @(negedge clk);
            if (b4.next === 1'b1) pulses++;
            e  = (c == 6);
            ea = (c < 6) ? 16'd0 : 16'd150;
            checks++; if (b4.next !== e) begin errors++; $display("FAIL rpost_next c=%0d got %b expected %b", c, b4.next, e); end
            checks++; if (b4.amplitude !== ea) begin errors++; $display("FAIL rpost_amp c=%0d got %0d expected %0d", c, b4.amplitude, ea); end
        end
        b4.in_valid = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL rpost_pulses got %0d expected 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int gpk;
        int m;
        logic [15:0] exp_amp;
        logic signed [15:0] ri, rq;
        pulses = 0;
        gpk = 0;
        for (int c = 0; c < 1030; c++) begin
            if (c < 1024) begin
                ri = 16'($urandom_range(0, 65535));
                rq = 16'($urandom_range(0, 65535));
                if (c == 5) ri = 16'sh8000;
                if (c == 9) rq = 16'sd32767;
                if (c == 13) begin ri = 16'sd0; rq = 16'sd0; end
                b4.in_i = ri; b4.in_q = rq; b4.in_valid = 1'b1;
                m = ref_mag(ri, rq);
                if (m > gpk) gpk = m;
                if (c % 4 == 3) begin
                    exp_q.push_back(16'(gpk));
                    gpk = 0;
                end
            end else begin
                b4.in_valid = 1'b0;
            end
            @(negedge clk);
            if (b4.next === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_pulse c=%0d got %0d expected none", c, b4.amplitude);
                end else begin
                    exp_amp = exp_q.pop_front();
                    if (b4.amplitude !== exp_amp) begin errors++; $display("FAIL b2b_amp c=%0d got %0d expected %0d", c, b4.amplitude, exp_amp); end
                end
            end
        end
        checks++; if (pulses != 256) begin errors++; $display("FAIL b2b_pulses got %0d expected 256", pulses); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        b1.in_i = '0; b1.in_q = '0; b1.in_valid = 1'b0; b1.clear_clip = 1'b0;
        b4.in_i = '0; b4.in_q = '0; b4.in_valid = 1'b0; b4.clear_clip = 1'b0;
        test_reset();
        test_latency();
        test_swap();
        test_clip();
        test_window();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
